// File: rtl/rise_event_tracker.sv
`timescale 1ns/1ps
// rise_event_tracker: synchronizes a_in, flags its edges and queues timestamped rise events in a 2-deep buffer
module rise_event_tracker #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W = 8,
    parameter int TS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic [3:0]       b_in,
    input  logic             clr_i,
    input  logic             evt_ready,
    output logic             rose_o,
    output logic             fell_o,
    output logic             evt_valid,
    output logic [3:0]       evt_data,
    output logic [TS_W-1:0]  evt_time,
    output logic [CNT_W-1:0] rise_count,
    output logic             overflow
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic r_prev;
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_head_ts;
    logic [TS_W-1:0] r_tail_ts;
    logic [3:0] r_head_d;
    logic [3:0] r_tail_d;
    logic [CNT_W-1:0] r_cnt;
    logic r_ovf;
    logic w_sync;
    logic w_pop;
    logic w_drop;
    assign w_sync = r_sync[SYNC_STAGES-1];
    assign rose_o = w_sync & ~r_prev;
    assign fell_o = ~w_sync & r_prev;
    assign evt_valid = r_state != EMPTY;
    assign evt_data = r_head_d;
    assign evt_time = r_head_ts;
    assign rise_count = r_cnt;
    assign overflow = r_ovf;
    assign w_pop = evt_valid & evt_ready;
    assign w_drop = rose_o & ~w_pop & (r_state == FULL);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_ts <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], a_in};
            r_prev <= w_sync;
            r_ts <= r_ts + 1'b1;
            r_cnt <= clr_i ? CNT_W'(rose_o) : r_cnt + CNT_W'(rose_o && !(&r_cnt));
            r_ovf <= w_drop | (r_ovf & ~clr_i);
        end
    // head is always the oldest entry; a pop in FULL promotes the tail
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= EMPTY;
            r_head_d <= '0;
            r_head_ts <= '0;
            r_tail_d <= '0;
            r_tail_ts <= '0;
        end else begin
            case (r_state)
                EMPTY: if (rose_o) begin
                    r_head_d <= b_in;
                    r_head_ts <= r_ts;
                    r_state <= ONE;
                end
                ONE: if (rose_o && w_pop) begin
                    r_head_d <= b_in;
                    r_head_ts <= r_ts;
                end else if (rose_o) begin
                    r_tail_d <= b_in;
                    r_tail_ts <= r_ts;
                    r_state <= FULL;
                end else if (w_pop) begin
                    r_state <= EMPTY;
                end
                FULL: if (w_pop) begin
                    r_head_d <= r_tail_d;
                    r_head_ts <= r_tail_ts;
                    if (rose_o) begin
                        r_tail_d <= b_in;
                        r_tail_ts <= r_ts;
                    end else begin
                        r_state <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
endmodule

// File: tb/tb_rise_event_tracker.sv
`timescale 1ns/1ps
// tb_rise_event_tracker: directed stimulus against a queue-based event model checked every cycle
module tb_rise_event_tracker;
    localparam int S = 2;
    logic clk = 0;
    logic rst = 1;
    logic a_in = 0;
    logic clr_i = 0;
    logic evt_ready = 0;
    logic [3:0] b_in = 0;
    logic rose_o, fell_o, evt_valid, overflow;
    logic [3:0] evt_data;
    logic [7:0] evt_time, rise_count;
    logic s_rose, s_fell, s_valid, s_ovf;
    logic [3:0] s_data;
    logic [7:0] s_time;
    logic [1:0] s_cnt;
    int n_pass = 0;
    int n_tot = 0;
    int n_rose = 0;
    int n_fell = 0;
    int n_pop = 0;
    logic [11:0] m_q[$];
    logic m_hist[$];
    logic m_rose, m_fell, m_ovf;
    logic [7:0] m_ts;
    int m_cnt, m_cnt2;

    always #5 clk = ~clk;

    rise_event_tracker #(.SYNC_STAGES(S)) u_dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .clr_i(clr_i), .evt_ready(evt_ready),
        .rose_o(rose_o), .fell_o(fell_o), .evt_valid(evt_valid), .evt_data(evt_data),
        .evt_time(evt_time), .rise_count(rise_count), .overflow(overflow)
    );

    rise_event_tracker #(.SYNC_STAGES(S), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .clr_i(clr_i), .evt_ready(evt_ready),
        .rose_o(s_rose), .fell_o(s_fell), .evt_valid(s_valid), .evt_data(s_data),
        .evt_time(s_time), .rise_count(s_cnt), .overflow(s_ovf)
    );

    task automatic chk(string name, longint act, longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic rise(logic [3:0] b);
        a_in = 1;
        b_in = b;
        tick(2);
        a_in = 0;
        tick(2);
    endtask

    // model: a_sync is the a_in sample taken S-1 edges ago, the buffer is a bounded FIFO
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q = {};
            m_hist = {};
            repeat (S + 1) m_hist.push_back(1'b0);
            m_rose = 0;
            m_fell = 0;
            m_ovf = 0;
            m_ts = 0;
            m_cnt = 0;
            m_cnt2 = 0;
        end else begin : upd
            automatic bit drop = 1'b0;
            if (m_q.size() != 0 && evt_ready) void'(m_q.pop_front());
            if (m_rose) begin
                if (m_q.size() < 2) m_q.push_back({b_in, m_ts});
                else drop = 1'b1;
            end
            m_ovf = drop || (m_ovf && !clr_i);
            m_cnt = clr_i ? int'(m_rose) : (m_rose && m_cnt < 255) ? m_cnt + 1 : m_cnt;
            m_cnt2 = clr_i ? int'(m_rose) : (m_rose && m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
            m_ts++;
            m_hist.push_front(a_in);
            void'(m_hist.pop_back());
            m_rose = m_hist[S-1] && !m_hist[S];
            m_fell = !m_hist[S-1] && m_hist[S];
        end
    end

    initial forever begin
        @(negedge clk);
        chk("rose_o", rose_o, m_rose);
        chk("fell_o", fell_o, m_fell);
        chk("evt_valid", evt_valid, m_q.size() != 0);
        chk("overflow", overflow, m_ovf);
        chk("rise_count", rise_count, m_cnt);
        chk("sat_count", s_cnt, m_cnt2);
        chk("sat_overflow", s_ovf, m_ovf);
        if (m_q.size() != 0) begin
            chk("evt_data", evt_data, m_q[0][11:8]);
            chk("evt_time", evt_time, m_q[0][7:0]);
        end
        n_rose += int'(rose_o);
        n_fell += int'(fell_o);
        n_pop += int'(evt_valid && evt_ready);
    end

    initial begin
        tick(3);
        chk("rst_rose", rose_o, 0);
        chk("rst_fell", fell_o, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_data", evt_data, 0);
        chk("rst_time", evt_time, 0);
        chk("rst_count", rise_count, 0);
        chk("rst_ovf", overflow, 0);
        rst = 0;
        tick(2);
        a_in = 1;
        b_in = 4'b0101;
        tick();
        chk("single_rose_c3", rose_o, 0);
        tick();
        chk("single_rose_c4", rose_o, 1);
        tick();
        chk("single_rose_c5", rose_o, 0);
        chk("single_valid", evt_valid, 1);
        chk("single_data", evt_data, 4'b0101);
        chk("single_time", evt_time, 4);
        chk("single_count", rise_count, 1);
        a_in = 0;
        evt_ready = 1;
        tick();
        evt_ready = 0;
        clr_i = 1;
        tick();
        clr_i = 0;
        evt_ready = 1;
        tick(3);
        n_rose = 0;
        n_fell = 0;
        for (int i = 0; i < 6; i++) rise(4'(i + 1));
        tick(4);
        chk("train_count", rise_count, 6);
        chk("train_ovf", overflow, 0);
        chk("train_rose", n_rose, 6);
        chk("train_fell", n_fell, 6);
        evt_ready = 0;
        clr_i = 1;
        tick();
        clr_i = 0;
        rise(4'hA);
        rise(4'hB);
        rise(4'hC);
        tick(2);
        chk("bp_ovf", overflow, 1);
        chk("bp_count", rise_count, 3);
        chk("bp_data", evt_data, 4'hA);
        n_pop = 0;
        evt_ready = 1;
        tick(4);
        chk("bp_pops", n_pop, 2);
        chk("bp_empty", evt_valid, 0);
        evt_ready = 0;
        clr_i = 1;
        tick();
        clr_i = 0;
        rise(4'h1);
        rise(4'h2);
        a_in = 1;
        b_in = 4'h3;
        tick(2);
        evt_ready = 1;
        tick();
        evt_ready = 0;
        a_in = 0;
        chk("sim_valid", evt_valid, 1);
        chk("sim_ovf", overflow, 0);
        chk("sim_head", evt_data, 4'h2);
        evt_ready = 1;
        tick();
        evt_ready = 0;
        chk("sim_tail", evt_data, 4'h3);
        chk("sim_tail_valid", evt_valid, 1);
        evt_ready = 1;
        tick(2);
        chk("sim_empty", evt_valid, 0);
        evt_ready = 0;
        clr_i = 1;
        tick();
        clr_i = 0;
        for (int i = 0; i < 5; i++) rise(4'(i + 7));
        tick(2);
        chk("sat_cnt3", s_cnt, 3);
        chk("sat_main5", rise_count, 5);
        chk("sat_ovf1", overflow, 1);
        evt_ready = 1;
        tick(3);
        a_in = 1;
        tick(2);
        clr_i = 1;
        tick();
        clr_i = 0;
        a_in = 0;
        chk("clr_rose_sat", s_cnt, 1);
        chk("clr_rose_main", rise_count, 1);
        chk("clr_rose_ovf", overflow, 0);
        tick(2);
        evt_ready = 0;
        rise(4'h4);
        rise(4'h5);
        a_in = 1;
        tick(2);
        clr_i = 1;
        tick();
        clr_i = 0;
        a_in = 0;
        chk("clr_drop_ovf", overflow, 1);
        chk("clr_drop_count", rise_count, 1);
        evt_ready = 1;
        tick(3);
        evt_ready = 0;
        rise(4'h6);
        tick();
        chk("mid_one", evt_valid, 1);
        a_in = 1;
        #1 rst = 1;
        #1;
        chk("mid_valid", evt_valid, 0);
        chk("mid_rose", rose_o, 0);
        chk("mid_fell", fell_o, 0);
        chk("mid_data", evt_data, 0);
        chk("mid_time", evt_time, 0);
        chk("mid_count", rise_count, 0);
        chk("mid_ovf", overflow, 0);
        #2 rst = 0;
        tick();
        chk("rel_rose_c1", rose_o, 0);
        tick();
        chk("rel_rose_c2", rose_o, 1);
        tick();
        chk("rel_valid", evt_valid, 1);
        chk("rel_time", evt_time, 2);
        chk("rel_count", rise_count, 1);
        evt_ready = 1;
        a_in = 0;
        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/rise_event_tracker.md
RISE_EVENT_TRACKER -- requirements
Module: rise_event_tracker

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on a_in, legal range 2..4.
REQ-002 Parameter CNT_W, default 8: width of rise_count.
REQ-003 Parameter TS_W, default 8: width of the timestamp counter and evt_time.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous assert, active-high.
REQ-006 Port a_in  input  1  asynchronous monitored signal.
REQ-007 Port b_in  input  4  synchronous side data, captured with each rise.
REQ-008 Port clr_i  input  1  synchronous clear of rise_count and overflow.
REQ-009 Port evt_ready  input  1  consumer ready.
REQ-010 Port rose_o  output  1  one-cycle rising-edge pulse.
REQ-011 Port fell_o  output  1  one-cycle falling-edge pulse.
REQ-012 Port evt_valid  output  1  event available at head of buffer.
REQ-013 Port evt_data  output  4  b_in captured at the head event.
REQ-014 Port evt_time  output  TS_W  timestamp of the head event.
REQ-015 Port rise_count  output  CNT_W  saturating count of detected rises.
REQ-016 Port overflow  output  1  sticky flag: an event was dropped.

Function
REQ-017 a_in passes through a SYNC_STAGES-flop chain; the last stage is a_sync, and a_prev is a_sync delayed one cycle.
REQ-018 rose_o = a_sync & ~a_prev; fell_o = ~a_sync & a_prev; both are decoded from registers and are free of glitches.
REQ-019 Latency: a_in high at posedge N (previously low) -> rose_o high from posedge N+SYNC_STAGES-1 to posedge N+SYNC_STAGES, exactly one cycle.
REQ-020 An a_in pulse shorter than one clock period is either missed or reported as one rose_o/fell_o pair, never as a partial event.
REQ-021 A free-running TS_W-bit counter ts increments every cycle, wraps from all-ones to 0, and is not affected by clr_i.
REQ-022 Each rose_o cycle produces a push of the event {b_in, ts} from that same cycle into a 2-entry in-order buffer.
REQ-023 Buffer state machine has three states: EMPTY, ONE, FULL.
  - Push moves EMPTY->ONE and ONE->FULL.
  - Pop (evt_valid & evt_ready) moves FULL->ONE and ONE->EMPTY.
  - Push and pop in the same cycle hold the state.
REQ-024 evt_valid = (state != EMPTY); evt_data and evt_time always show the oldest entry and stay stable while evt_valid & ~evt_ready.
REQ-025 In FULL with a push and a pop in the same cycle, the head is popped and the new event is accepted; overflow is not set.
REQ-026 In FULL with a push and no pop, the new event is dropped, the buffer is unchanged, and overflow is set to 1.
REQ-027 overflow stays 1 until clr_i or rst.
REQ-028 In EMPTY with a push, evt_valid asserts the cycle after rose_o; there is no combinational bypass.
REQ-029 rise_count increments on every rose_o, including dropped events, and saturates at 2^CNT_W-1.
REQ-030 clr_i sets rise_count to 0 and overflow to 0.
  - clr_i together with rose_o gives rise_count = 1.
  - clr_i together with a drop gives overflow = 1.
REQ-031 clr_i does not affect the buffer contents or its state.

Reset
REQ-032 While rst is high, the sync chain, a_prev, ts and rise_count are 0, the buffer is EMPTY and overflow is 0.
REQ-033 While rst is high, the outputs are rose_o=0, fell_o=0, evt_valid=0, evt_data=0, evt_time=0, rise_count=0, overflow=0.
REQ-034 Reset asserted mid-operation discards any buffered events immediately, without waiting for a clock edge.
REQ-035 If a_in is already high when reset releases, it is reported as a rise after SYNC_STAGES cycles.

Verification
REQ-036 Single edge: rst released, a_in 0->1 at posedge 3, SYNC_STAGES=2, b_in=4'b0101 -> rose_o high only in cycle 4; the next cycle shows evt_valid=1, evt_data=0101, evt_time=4, rise_count=1.
REQ-037 Toggle train: a_in toggling every 2 cycles for 6 rises, evt_ready=1 -> six rose_o and six fell_o pulses; rise_count=6; overflow=0; events delivered in order.
REQ-038 Backpressure: evt_ready=0 and three rises -> first two events are held and stable, overflow=1, rise_count=3; then evt_ready=1 drains exactly two events.
REQ-039 Simultaneous: buffer FULL, push and pop in the same cycle -> state stays FULL, the new event becomes the tail, overflow stays 0.
REQ-040 Clear/saturate: CNT_W=2 and 5 rises -> rise_count=3; clr_i together with rose_o -> rise_count=1 and overflow=0.
REQ-041 Reset mid-stream: rst pulsed asynchronously between clock edges with the buffer in ONE -> evt_valid drops immediately and all outputs take their REQ-033 values.
